pll_reset_seq: RTL and testbench
================================

Name: pll_reset_seq

Overview:
- Reset sequencer for the board clock tree; runs on the free-running 25 MHz board oscillator, which also feeds the PLL.
- Watches the PLL lock output and holds the system reset until lock has been stable long enough.
- Pulses the PLL reset input if lock does not arrive within a timeout.
- Re-asserts system reset and counts the event whenever lock is lost during operation.

Parameters:
SYNC_STAGES, 2, flop stages synchronising the asynchronous locked input (minimum 2)
STABLE_CYCLES, 1024, consecutive synchronised-lock-high cycles required before reset release
LOCK_TIMEOUT, 65536, cycles in WAIT_LOCK without lock before a PLL reset is issued
PLL_RST_CYCLES, 16, width of the pll_rst pulse in cycles
CNT_W, 17, internal counter width; must hold max(STABLE_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES)

Ports:
clk  in  1  free-running board clock (25 MHz), same source as the PLL CLKI
resetn  in  1  asynchronous active-low reset
locked  in  1  PLL LOCK output, asynchronous to clk
pll_rst  out  1  active-high reset request to the PLL RST pin
reset_out  out  1  active-high system reset; downstream domains resynchronise it locally
ready  out  1  high while the FSM is in RUN
lock_loss_count  out  8  saturating count of RUN-to-unlock events
pll_retry_count  out  4  saturating count of PLL resets issued

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- While resetn=0 (async, takes effect immediately, including mid-operation):
  - state=WAIT_LOCK; counter=0; sync chain all 0.
  - reset_out=1, pll_rst=0, ready=0, both counts 0.
- locked passes through a SYNC_STAGES flop chain; the FSM uses only the chain output lk.
- Let t0 be the first clk edge that samples locked=1. lk is high after edge t0+SYNC_STAGES-1.
- Lock pulses narrower than one clk period may be missed. This is accepted.
- All outputs are registered. reset_out=0 exactly when state=RUN. ready = ~reset_out.
- States and transitions:
  - WAIT_LOCK:
    - lk=1: counter<=0, go STABLE.
    - Else if counter==LOCK_TIMEOUT-1: counter<=0, pll_retry_count+=1 (saturate at 15), go PLL_RST.
    - Else counter+=1.
  - STABLE:
    - lk=0: counter<=0, go WAIT_LOCK. The timeout restarts from 0.
    - Else if counter==STABLE_CYCLES-1: go RUN.
    - Else counter+=1.
  - PLL_RST:
    - pll_rst=1 for exactly PLL_RST_CYCLES cycles.
    - Then pll_rst<=0, counter<=0, go WAIT_LOCK.
    - lk is ignored in this state.
  - RUN:
    - lk=0: reset_out<=1 on that edge, lock_loss_count+=1 (saturate at 255), counter<=0, go WAIT_LOCK.
- Latency:
  - reset_out first samples 0 at edge t0+SYNC_STAGES+STABLE_CYCLES, provided locked stays high throughout.
  - After locked falls at first sampling edge t1, reset_out first samples 1 at edge t1+SYNC_STAGES.
- Counters never wrap. Saturation holds the value until resetn.
- If lk rises in the same cycle WAIT_LOCK reaches its timeout, lk wins: go STABLE, no retry.
- There is no path from RUN to PLL_RST except through WAIT_LOCK timeout.

Test Plan:
All scenarios use SYNC_STAGES=2, STABLE_CYCLES=8, LOCK_TIMEOUT=32, PLL_RST_CYCLES=4.
1. Reset values: hold resetn=0 with locked=1 -> reset_out=1, ready=0, pll_rst=0, counts 0. Release resetn with locked=1 sampled at t0 -> reset_out first 0 at edge t0+10, ready=1.
2. Lock bounce: locked high 5 cycles, low 1, then high -> no reset release until 8 consecutive lk-high cycles after the bounce; lock_loss_count stays 0.
3. Timeout: locked=0 permanently -> pll_rst high for exactly 4 cycles after 32 WAIT_LOCK cycles, repeating. pll_retry_count is 1, 2, ... and saturates at 15 after 15 pulses.
4. Lock loss: reach RUN, then drop locked at edge t1 -> reset_out=1 at edge t1+2, lock_loss_count=1. Reassert locked -> RUN again after 2+8 cycles. Repeat 260 times -> count saturates at 255.
5. Async reset mid-operation: assert resetn=0 between clock edges while in STABLE and while in PLL_RST -> reset_out=1 and pll_rst=0 immediately, without waiting for a clk edge, and counts cleared.
6. Race: lk rises exactly on the cycle the counter reaches 31 in WAIT_LOCK -> state goes STABLE, pll_rst stays 0, pll_retry_count unchanged.

Source files
------------

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: board-clock reset sequencer.
// Synchronises the PLL lock flag and holds system reset until lock has been
// stable for STABLE_CYCLES cycles. If lock does not arrive within
// LOCK_TIMEOUT cycles, it pulses the PLL reset. If lock drops while
// running, it re-asserts reset and counts the event.
module pll_reset_seq #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned CNT_W          = 17
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       locked,
  output logic       pll_rst,
  output logic       reset_out,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic [3:0] pll_retry_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    PLL_RST   = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counts. Each state compares against its own last value, so the
  // single counter is shared between the timeout, stability and pulse phases.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PLL_RST_CYCLES - 1);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lk;

  // The lock flag comes straight from the PLL analog block, so it is
  // resynchronised here. Only the last stage is visible to the FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync <= '0;
    else         sync <= {sync[SYNC_STAGES-2:0], locked};
  end

  assign lk = sync[SYNC_STAGES-1];

  // Sequencer FSM. All outputs are registered, and each output is updated
  // on the same edge as the state change that implies it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      pll_rst         <= 1'b0;
      reset_out       <= 1'b1;
      ready           <= 1'b0;
      lock_loss_count <= '0;
      pll_retry_count <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          // Lock takes priority over an expiring timeout.
          if (lk) begin
            cnt   <= '0;
            state <= STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (pll_retry_count != 4'hF) pll_retry_count <= pll_retry_count + 4'd1;
            state   <= PLL_RST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE: begin
          // Any glitch low restarts the whole lock search, including the timeout.
          if (!lk) begin
            cnt   <= '0;
            state <= WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            cnt       <= '0;
            reset_out <= 1'b0;
            ready     <= 1'b1;
            state     <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PLL_RST: begin
          // Lock is meaningless while the PLL is held in reset, so it is ignored.
          if (cnt == PULSE_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b0;
            state   <= WAIT_LOCK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            reset_out <= 1'b1;
            ready     <= 1'b0;
            if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
            cnt       <= '0;
            state     <= WAIT_LOCK;
          end
        end
        default: begin
          cnt       <= '0;
          pll_rst   <= 1'b0;
          reset_out <= 1'b1;
          ready     <= 1'b0;
          state     <= WAIT_LOCK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq. The stimulus pushes the expected
// output changes as (cycle, value) records. A monitor samples the outputs
// after every falling clock edge and after every reset assertion. Whenever
// the sampled outputs change, it pops the next record and compares it.
module tb_pll_reset_seq;

  logic       clk = 1'b0;
  logic       resetn;
  logic       locked;
  logic       pll_rst, reset_out, ready;
  logic [7:0] lock_loss_count;
  logic [3:0] pll_retry_count;

  typedef struct packed {
    logic       pr;
    logic       ro;
    logic       rd;
    logic [7:0] llc;
    logic [3:0] prc;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } ev_t;

  ev_t q[$];
  int  cyc    = 0;
  int  n_cmp  = 0;
  int  n_bad  = 0;
  int  llc_m  = 0;

  pll_reset_seq #(
    .SYNC_STAGES(2), .STABLE_CYCLES(8), .LOCK_TIMEOUT(32), .PLL_RST_CYCLES(4), .CNT_W(17)
  ) dut (
    .clk(clk), .resetn(resetn), .locked(locked), .pll_rst(pll_rst),
    .reset_out(reset_out), .ready(ready), .lock_loss_count(lock_loss_count),
    .pll_retry_count(pll_retry_count)
  );

  always #5 clk = ~clk;

  // Edge number k completes at time 10k-5. After that edge, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic pr, input logic ro, input int llc, input int prc);
    ev_t e;
    e.cyc = c;
    e.o   = {pr, ro, ~ro, 8'(llc), 4'(prc)};
    q.push_back(e);
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: compares every observed output change against the next expected record.
  obs_t last = 'x;
  always begin
    obs_t cur;
    ev_t  e;
    @(negedge clk or negedge resetn);
    #1;
    cur = {pll_rst, reset_out, ready, lock_loss_count, pll_retry_count};
    if (cur !== last) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got pr=%b ro=%b rd=%b llc=%0d prc=%0d",
                 cyc, cur.pr, cur.ro, cur.rd, cur.llc, cur.prc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.o !== cur) begin
          n_bad++;
          $display("FAIL output_event got cyc=%0d pr=%b ro=%b rd=%b llc=%0d prc=%0d, expected cyc=%0d pr=%b ro=%b rd=%b llc=%0d prc=%0d",
                   cyc, cur.pr, cur.ro, cur.rd, cur.llc, cur.prc,
                   e.cyc, e.o.pr, e.o.ro, e.o.rd, e.o.llc, e.o.prc);
        end
      end
      last = cur;
    end
  end

  initial begin
    // 1. Reset values with locked already high; release -> RUN at t0+10.
    resetn = 1'b1;
    locked = 1'b1;
    push(0, 0, 1, 0, 0);
    #2 resetn = 1'b0;
    to_cyc(3);
    resetn = 1'b1;            // t0 = 4
    push(14, 0, 0, 0, 0);

    // Async reset while in RUN, then a lock bounce from a fresh start.
    to_cyc(20);
    push(20, 0, 1, 0, 0);
    #2 resetn = 1'b0;
    locked = 1'b0;
    to_cyc(22);
    resetn = 1'b1;
    // Locked high for 5 samples (26..30), low at 31, high from 32 -> RUN at 42.
    push(42, 0, 0, 0, 0);
    to_cyc(25); locked = 1'b1;
    to_cyc(30); locked = 1'b0;
    to_cyc(31); locked = 1'b1;

    // 4. Lock loss: drop at t1=b+1 -> reset at b+3; relock at t0=b+4 -> RUN at b+14.
    for (int i = 0; i < 260; i++) begin
      int b;
      b = 50 + 16 * i;
      if (llc_m < 255) llc_m++;
      push(b + 3, 0, 1, llc_m, 0);
      push(b + 14, 0, 0, llc_m, 0);
      to_cyc(b);     locked = 1'b0;
      to_cyc(b + 3); locked = 1'b1;
    end

    // 5a. Async reset while in STABLE, with saturated loss count.
    push(4213, 0, 1, 255, 0);
    push(4219, 0, 1, 0, 0);
    to_cyc(4210); locked = 1'b0;
    to_cyc(4213); locked = 1'b1;   // STABLE from edge 4216
    to_cyc(4219);
    #2 resetn = 1'b0;
    locked = 1'b0;
    to_cyc(4221);
    resetn = 1'b1;

    // 3. Timeout: pulse n rises at 4253+36(n-1), lasts 4 cycles, and the retry count saturates at 15.
    for (int n = 1; n <= 16; n++) begin
      int r;
      r = 4253 + 36 * (n - 1);
      push(r,     1, 1, 0, (n > 15) ? 15 : n);
      push(r + 4, 0, 1, 0, (n > 15) ? 15 : n);
    end
    // 5b. Async reset in the middle of pulse 17.
    push(4829, 1, 1, 0, 15);
    push(4830, 0, 1, 0, 0);
    to_cyc(4830);
    #2 resetn = 1'b0;
    to_cyc(4832);
    resetn = 1'b1;

    // 6. Race: the timeout would fire at edge 4864. Lock is first sampled at 4862,
    //    so lk is seen at 4864 and wins. That gives RUN at 4872 with no pulse.
    push(4872, 0, 0, 0, 0);
    to_cyc(4861); locked = 1'b1;

    to_cyc(4890);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events got %0d left, expected 0 (next cyc=%0d)", q.size(), q[0].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog got time limit, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
